// File: rtl/rf_wb_if.sv
// Bundle of decode-issue, pipeline writeback, long-latency result and regfile write signals
// for the shared regfile write port arbiter.
interface rf_wb_if;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic [4:0]  issue_rd;
    logic        issue_long;
    logic        issue_stall;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lu_err;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rd, issue_long,
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        input  issue_stall, lu_ready, rf_we, rf_waddr, rf_wdata, lu_err
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rd, issue_long,
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        output issue_stall, lu_ready, rf_we, rf_waddr, rf_wdata, lu_err
    );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Regfile write-port arbiter: pipeline writes win, long-latency results queue and drain into
// idle slots, and a busy scoreboard stalls issue on hazards against in-flight LU destinations.
module rf_wb_scoreboard #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic    clk,
    input logic    rst,
    rf_wb_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      busy;
    logic [31:0]      busy_nxt;
    logic [STV_W-1:0] starve_cnt;
    logic             lu_err_q;

    logic        full;
    logic        empty;
    logic        pipe_slot;
    logic        drain;
    logic        push;
    logic        fire;
    logic        starve;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // A pipeline write to x0 leaves the port free for the FIFO.
    assign pipe_slot = bus.pipe_we & (bus.pipe_waddr != 5'd0);
    assign drain     = !rst & !pipe_slot & !empty;

    assign bus.lu_ready = !rst & !full;
    assign push         = bus.lu_valid & bus.lu_ready;

    // Entries aimed at x0 still pop but never reach the regfile.
    assign bus.rf_we    = !rst & (pipe_slot | (!empty & (head_addr != 5'd0)));
    assign bus.rf_waddr = pipe_slot ? bus.pipe_waddr : head_addr;
    assign bus.rf_wdata = pipe_slot ? bus.pipe_wdata : head_data;

    assign starve          = (starve_cnt == STV_W'(STARVE_LIMIT));
    assign bus.issue_stall = bus.issue_valid &
                             (busy[bus.issue_rs] | busy[bus.issue_rt] |
                              (bus.issue_long & busy[bus.issue_rd]) | starve);
    assign fire            = bus.issue_valid & !bus.issue_stall;
    assign bus.lu_err      = lu_err_q;

    always_comb begin
        busy_nxt = busy;
        if (drain)
            busy_nxt[head_addr] = 1'b0;
        if (fire && bus.issue_long && (bus.issue_rd != 5'd0))
            busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            busy       <= '0;
            starve_cnt <= '0;
            lu_err_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            busy <= busy_nxt;
            if (empty || drain)
                starve_cnt <= '0;
            else if (!starve)
                starve_cnt <= starve_cnt + STV_W'(1);
            if (push && (bus.lu_waddr != 5'd0) && !busy[bus.lu_waddr])
                lu_err_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the control state above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.lu_waddr;
            fifo_data[wr_ptr] <= bus.lu_wdata;
        end
    end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rf_wb_scoreboard;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_if bus ();

    rf_wb_scoreboard #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued results, busy set, blocked-cycle count, sticky error.
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t     q[$];
    bit [31:0] m_busy = '0;
    int       m_blk   = 0;
    bit       m_err   = 1'b0;

    always @(negedge clk) begin
        bit          pslot, e_ready, e_we, e_stall, do_drain, push, fire;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        ent_t        ne;
        if (chk_en) begin
            pslot    = bus.pipe_we && (bus.pipe_waddr != 0);
            e_ready  = !rst && (q.size() < FIFO_DEPTH);
            e_we     = 1'b0;
            e_addr   = '0;
            e_data   = '0;
            do_drain = 1'b0;
            if (!rst && pslot) begin
                e_we = 1'b1; e_addr = bus.pipe_waddr; e_data = bus.pipe_wdata;
            end else if (!rst && q.size() > 0) begin
                do_drain = 1'b1;
                e_we = (q[0].a != 0); e_addr = q[0].a; e_data = q[0].d;
            end
            e_stall = bus.issue_valid && (m_busy[bus.issue_rs] || m_busy[bus.issue_rt] ||
                      (bus.issue_long && m_busy[bus.issue_rd]) || (m_blk >= STARVE_LIMIT));

            check("m_rf_we", 32'(bus.rf_we), 32'(e_we));
            if (e_we) begin
                check("m_rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
                check("m_rf_wdata", bus.rf_wdata, e_data);
            end
            check("m_lu_ready", 32'(bus.lu_ready), 32'(e_ready));
            check("m_issue_stall", 32'(bus.issue_stall), 32'(e_stall));
            check("m_lu_err", 32'(bus.lu_err), 32'(m_err));

            if (rst) begin
                q.delete();
                m_busy = '0;
                m_blk  = 0;
                m_err  = 1'b0;
            end else begin
                push = bus.lu_valid && e_ready;
                fire = bus.issue_valid && !e_stall;
                if (push && bus.lu_waddr != 0 && !m_busy[bus.lu_waddr])
                    m_err = 1'b1;
                if (q.size() == 0 || do_drain)
                    m_blk = 0;
                else if (m_blk < STARVE_LIMIT)
                    m_blk++;
                if (do_drain) begin
                    m_busy[q[0].a] = 1'b0;
                    void'(q.pop_front());
                end
                if (fire && bus.issue_long && bus.issue_rd != 0)
                    m_busy[bus.issue_rd] = 1'b1;
                m_busy[0] = 1'b0;
                if (push) begin
                    ne.a = bus.lu_waddr;
                    ne.d = bus.lu_wdata;
                    q.push_back(ne);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input bit lng);
        bus.issue_valid = v; bus.issue_rs = rs; bus.issue_rt = rt;
        bus.issue_rd = rd; bus.issue_long = lng;
    endtask

    task automatic pipe(input bit we, input logic [4:0] a, input logic [31:0] d);
        bus.pipe_we = we; bus.pipe_waddr = a; bus.pipe_wdata = d;
    endtask

    task automatic lu(input bit v, input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid = v; bus.lu_waddr = a; bus.lu_wdata = d;
    endtask

    initial begin
        issue(0, 0, 0, 0, 0);
        pipe(0, 0, 0);
        lu(0, 0, 0);

        // Reset
        step();
        chk_en = 1'b1;
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
        check("rst_lu_err", 32'(bus.lu_err), 32'd0);
        step();
        rst = 1'b0;

        // Pipeline write passes straight through
        pipe(1, 3, 32'h11);
        #1;
        check("t1_rf_we", 32'(bus.rf_we), 32'd1);
        check("t1_rf_waddr", 32'(bus.rf_waddr), 32'd3);
        check("t1_rf_wdata", bus.rf_wdata, 32'h11);
        check("t1_lu_ready", 32'(bus.lu_ready), 32'd1);
        step();
        pipe(0, 0, 0);

        // RAW stall against LU destination r5
        issue(1, 1, 2, 5, 1);
        #1 check("t2_fire_long", 32'(bus.issue_stall), 32'd0);
        step();
        issue(1, 5, 2, 6, 0);
        lu(1, 5, 32'hAB);
        #1 check("t2_raw_stall", 32'(bus.issue_stall), 32'd1);
        step();
        lu(0, 0, 0);
        #1;
        check("t2_drain_we", 32'(bus.rf_we), 32'd1);
        check("t2_drain_addr", 32'(bus.rf_waddr), 32'd5);
        check("t2_drain_data", bus.rf_wdata, 32'hAB);
        check("t2_stall_on_drain", 32'(bus.issue_stall), 32'd1);
        step();
        check("t2_stall_drop", 32'(bus.issue_stall), 32'd0);
        step();
        issue(0, 0, 0, 0, 0);

        // Starvation under continuous pipeline writes
        issue(1, 1, 2, 10, 1);
        step();
        issue(1, 1, 2, 11, 1);
        step();
        issue(0, 0, 0, 0, 0);
        pipe(1, 7, 32'h77);
        lu(1, 10, 32'hA0);
        step();
        lu(1, 11, 32'hB0);
        step();
        lu(0, 0, 0);
        issue(1, 1, 2, 3, 0);
        #1;
        check("t3_full_ready", 32'(bus.lu_ready), 32'd0);
        check("t3_pipe_wins", 32'(bus.rf_waddr), 32'd7);
        check("t3_no_starve_yet", 32'(bus.issue_stall), 32'd0);
        step();
        step();
        check("t3_starve_minus1", 32'(bus.issue_stall), 32'd0);
        step();
        check("t3_starve", 32'(bus.issue_stall), 32'd1);
        step();
        pipe(0, 0, 0);
        #1;
        check("t3_drain_addr", 32'(bus.rf_waddr), 32'd10);
        check("t3_drain_data", bus.rf_wdata, 32'hA0);
        check("t3_starve_hold", 32'(bus.issue_stall), 32'd1);
        step();
        check("t3_starve_clear", 32'(bus.issue_stall), 32'd0);
        check("t3_drain2_addr", 32'(bus.rf_waddr), 32'd11);
        step();
        issue(0, 0, 0, 0, 0);

        // Full FIFO: pop this cycle, push refused until count drops
        issue(1, 1, 2, 12, 1);
        step();
        issue(1, 1, 2, 13, 1);
        step();
        issue(1, 1, 2, 14, 1);
        step();
        issue(0, 0, 0, 0, 0);
        pipe(1, 7, 32'h77);
        lu(1, 12, 32'hC0);
        step();
        lu(1, 13, 32'hD0);
        step();
        pipe(0, 0, 0);
        lu(1, 14, 32'hE0);
        #1;
        check("t4_refused", 32'(bus.lu_ready), 32'd0);
        check("t4_drain_addr", 32'(bus.rf_waddr), 32'd12);
        step();
        check("t4_accept", 32'(bus.lu_ready), 32'd1);
        check("t4_drain2_addr", 32'(bus.rf_waddr), 32'd13);
        step();
        lu(0, 0, 0);
        #1;
        check("t4_drain3_addr", 32'(bus.rf_waddr), 32'd14);
        check("t4_drain3_data", bus.rf_wdata, 32'hE0);
        step();
        check("t4_idle", 32'(bus.rf_we), 32'd0);
        check("t4_no_err", 32'(bus.lu_err), 32'd0);

        // Unexpected LU destination and x0 result
        lu(1, 9, 32'h99);
        step();
        lu(0, 0, 0);
        #1;
        check("t5_err_set", 32'(bus.lu_err), 32'd1);
        check("t5_r9_addr", 32'(bus.rf_waddr), 32'd9);
        check("t5_r9_we", 32'(bus.rf_we), 32'd1);
        step();
        lu(1, 0, 32'h55);
        step();
        lu(0, 0, 0);
        #1;
        check("t5_x0_no_we", 32'(bus.rf_we), 32'd0);
        check("t5_err_sticky", 32'(bus.lu_err), 32'd1);
        step();

        // Reset mid-operation
        issue(1, 1, 2, 5, 1);
        step();
        issue(0, 0, 0, 0, 0);
        pipe(1, 7, 32'h77);
        lu(1, 5, 32'h1);
        step();
        lu(1, 5, 32'h2);
        step();
        lu(0, 0, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_no_we", 32'(bus.rf_we), 32'd0);
        check("t6_rst_no_ready", 32'(bus.lu_ready), 32'd0);
        step();
        rst = 1'b0;
        pipe(0, 0, 0);
        issue(1, 5, 2, 6, 0);
        #1;
        check("t6_fifo_empty", 32'(bus.rf_we), 32'd0);
        check("t6_ready", 32'(bus.lu_ready), 32'd1);
        check("t6_busy_clear", 32'(bus.issue_stall), 32'd0);
        check("t6_err_clear", 32'(bus.lu_err), 32'd0);
        step();
        issue(0, 0, 0, 0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
